// File: rtl/decode.sv
// ID stage of the 5-stage pipeline: owns the 32x32 register file, decodes IF/ID,
// registers ID/EX, and retires write-backs of valD three edges after the ID/EX latch.
module decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IF_ID_IR,
    input  logic [31:0] IF_ID_NPC,
    input  logic [31:0] valD,
    output logic [31:0] ID_EX_IR,
    output logic [31:0] ID_EX_NPC,
    output logic [31:0] ID_EX_A,
    output logic [31:0] ID_EX_B,
    output logic [31:0] ID_EX_Imm
);

    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SLT = 6'h06;
    localparam logic [5:0] OP_LW  = 6'h08;
    localparam logic [5:0] OP_J   = 6'h0B;
    localparam int         WB_DELAY = 3;

    logic [31:0] rf_q [32];

    logic [31:0] ir_q, ir_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;

    logic [WB_DELAY-1:0]      wb_vld_q, wb_vld_d;
    logic [WB_DELAY-1:0][4:0] wb_dst_q, wb_dst_d;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic        dec_vld;
    logic [4:0]  dec_dst;
    logic        wb_en;
    logic [4:0]  wb_dst;

    always_comb begin
        op = IF_ID_IR[31:26];
        rs = IF_ID_IR[25:21];
        rt = IF_ID_IR[20:16];
        rd = IF_ID_IR[15:11];

        dec_vld = 1'b0;
        dec_dst = 5'd0;
        if (op >= OP_ADD && op <= OP_SLT) begin
            dec_vld = 1'b1;
            dec_dst = rd;
        end else if (op == OP_LW) begin
            dec_vld = 1'b1;
            dec_dst = rt;
        end
    end

    // Writes to R0 are dropped here so the bypass below never forwards into R0.
    assign wb_dst = wb_dst_q[WB_DELAY-1];
    assign wb_en  = wb_vld_q[WB_DELAY-1] && (wb_dst != 5'd0);

    always_comb begin
        ir_d  = IF_ID_IR;
        npc_d = IF_ID_NPC;

        if (op == OP_J)
            imm_d = {{6{IF_ID_IR[25]}}, IF_ID_IR[25:0]};
        else
            imm_d = {{16{IF_ID_IR[15]}}, IF_ID_IR[15:0]};

        // Same-edge write-back is forwarded so the operand matches the updated file.
        if (rs == 5'd0)
            a_d = 32'd0;
        else if (wb_en && wb_dst == rs)
            a_d = valD;
        else
            a_d = rf_q[rs];

        if (rt == 5'd0)
            b_d = 32'd0;
        else if (wb_en && wb_dst == rt)
            b_d = valD;
        else
            b_d = rf_q[rt];

        wb_vld_d = {wb_vld_q[WB_DELAY-2:0], dec_vld};
        wb_dst_d = {wb_dst_q[WB_DELAY-2:0], dec_dst};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q     <= 32'd0;
            npc_q    <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            imm_q    <= 32'd0;
            wb_vld_q <= '0;
            wb_dst_q <= '0;
        end else begin
            ir_q     <= ir_d;
            npc_q    <= npc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            wb_vld_q <= wb_vld_d;
            wb_dst_q <= wb_dst_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                rf_q[i] <= 32'(i);
        end else if (wb_en) begin
            rf_q[wb_dst] <= valD;
        end
    end

    assign ID_EX_IR  = ir_q;
    assign ID_EX_NPC = npc_q;
    assign ID_EX_A   = a_q;
    assign ID_EX_B   = b_q;
    assign ID_EX_Imm = imm_q;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: hand-derived vector table, scoreboard-checked random traffic
// against a reference model, and an asynchronous reset with a pending load.
module tb_decode;

    logic        clk;
    logic        rst_n;
    logic [31:0] IF_ID_IR, IF_ID_NPC, valD;
    logic [31:0] ID_EX_IR, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_Imm;

    decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .IF_ID_IR  (IF_ID_IR),
        .IF_ID_NPC (IF_ID_NPC),
        .valD      (valD),
        .ID_EX_IR  (ID_EX_IR),
        .ID_EX_NPC (ID_EX_NPC),
        .ID_EX_A   (ID_EX_A),
        .ID_EX_B   (ID_EX_B),
        .ID_EX_Imm (ID_EX_Imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] vald;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] m_reg [32];
    logic        m_v   [3];
    logic [4:0]  m_d   [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'(i);
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = 5'd0;
        end
    endtask

    // Drive one instruction, push its expected ID/EX contents, advance the model,
    // then pop and compare once the DUT has latched it.
    task automatic step(input logic [31:0] ir, input logic [31:0] npc, input logic [31:0] vald,
                        input logic use_tbl, input logic [31:0] ta, input logic [31:0] tb,
                        input logic [31:0] timm);
        exp_t        e;
        exp_t        got;
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic        wr;
        logic        dv;
        logic [4:0]  dd;
        @(negedge clk);
        IF_ID_IR  = ir;
        IF_ID_NPC = npc;
        valD      = vald;
        op = ir[31:26];
        rs = ir[25:21];
        rt = ir[20:16];
        wr = m_v[2] && (m_d[2] != 5'd0);
        e.ir  = ir;
        e.npc = npc;
        e.a   = (rs == 0) ? 32'd0 : (wr && m_d[2] == rs) ? vald : m_reg[rs];
        e.b   = (rt == 0) ? 32'd0 : (wr && m_d[2] == rt) ? vald : m_reg[rt];
        e.imm = (op == 6'h0B) ? {{6{ir[25]}}, ir[25:0]} : {{16{ir[15]}}, ir[15:0]};
        if (use_tbl) begin
            e.a   = ta;
            e.b   = tb;
            e.imm = timm;
        end
        sb_q.push_back(e);
        if (wr) m_reg[m_d[2]] = vald;
        dv = 1'b0;
        dd = 5'd0;
        if (op >= 6'h01 && op <= 6'h06) begin
            dv = 1'b1;
            dd = ir[15:11];
        end else if (op == 6'h08) begin
            dv = 1'b1;
            dd = rt;
        end
        m_v[2] = m_v[1]; m_d[2] = m_d[1];
        m_v[1] = m_v[0]; m_d[1] = m_d[0];
        m_v[0] = dv;     m_d[0] = dd;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            check("IR",  ID_EX_IR,  got.ir);
            check("NPC", ID_EX_NPC, got.npc);
            check("A",   ID_EX_A,   got.a);
            check("B",   ID_EX_B,   got.b);
            check("Imm", ID_EX_Imm, got.imm);
        end
    endtask

    vec_t tbl[12];

    initial begin
        logic [5:0]  ops [13];
        logic [5:0]  op;
        logic [31:0] ir;

        // Edge n of the table is vector n-1; write-backs land three vectors after their producer.
        tbl[0]  = '{32'h04221800, 32'h0,        32'd1,  32'd2,  32'h00001800}; // ADD r3,r1,r2
        tbl[1]  = '{32'h20850004, 32'h0,        32'd4,  32'd5,  32'h00000004}; // LW r5,4(r4)
        tbl[2]  = '{32'h00000000, 32'h0,        32'd0,  32'd0,  32'h00000000};
        tbl[3]  = '{32'h24630000, 32'h33,       32'h33, 32'h33, 32'h00000000}; // r3 bypass
        tbl[4]  = '{32'h2825FFFC, 32'h55,       32'd1,  32'h55, 32'hFFFFFFFC}; // r5 bypass
        tbl[5]  = '{32'h2FFFFFFF, 32'hAA,       32'd31, 32'd31, 32'hFFFFFFFF}; // J
        tbl[6]  = '{32'h2085FFFC, 32'hBB,       32'd4,  32'h55, 32'hFFFFFFFC};
        tbl[7]  = '{32'h04650000, 32'hCC,       32'h33, 32'h55, 32'h00000000}; // ADD r0 dest
        tbl[8]  = '{32'h04650000, 32'h99,       32'h33, 32'h55, 32'h00000000};
        tbl[9]  = '{32'h04650000, 32'h77,       32'h33, 32'h77, 32'h00000000};
        tbl[10] = '{32'h04000000, 32'h12345678, 32'd0,  32'd0,  32'h00000000};
        tbl[11] = '{32'h04A00000, 32'h0,        32'h77, 32'd0,  32'h00000000};

        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h3F, 6'h07};

        rst_n     = 1'b0;
        IF_ID_IR  = 32'h04221800;
        IF_ID_NPC = 32'h4;
        valD      = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_IR",  ID_EX_IR,  32'd0);
        check("rst_NPC", ID_EX_NPC, 32'd0);
        check("rst_A",   ID_EX_A,   32'd0);
        check("rst_B",   ID_EX_B,   32'd0);
        check("rst_Imm", ID_EX_Imm, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            step(tbl[i].ir, 32'(4 * (i + 1)), tbl[i].vald, 1'b1, tbl[i].a, tbl[i].b, tbl[i].imm);

        for (int i = 0; i < 300; i++) begin
            op = ops[$urandom_range(0, 12)];
            ir = {op, 26'($urandom)};
            step(ir, $urandom, $urandom, 1'b0, 32'd0, 32'd0, 32'd0);
        end

        // Pending LW r5 must be discarded by a mid-cycle reset.
        step(32'h20850004, 32'h100, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_IR",  ID_EX_IR,  32'd0);
        check("mrst_NPC", ID_EX_NPC, 32'd0);
        check("mrst_A",   ID_EX_A,   32'd0);
        check("mrst_B",   ID_EX_B,   32'd0);
        check("mrst_Imm", ID_EX_Imm, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            step(32'h00A50000, 32'h200, 32'hDEAD, 1'b1, 32'd5, 32'd5, 32'd0);

        for (int i = 0; i < 100; i++) begin
            op = ops[$urandom_range(0, 12)];
            ir = {op, 26'($urandom)};
            step(ir, $urandom, $urandom, 1'b0, 32'd0, 32'd0, 32'd0);
        end

        check("sb_left", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
